hls_io_frame: RTL

HLS_IO_FRAME -- requirements
Module: hls_io_frame

---
 rtl/hls_io_frame.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/hls_io_frame.sv
// rtl/hls_io_frame.sv - operand framing, launch, result capture and emit wrapper around an HLS controller
module hls_io_frame #(
    parameter int WIDTH   = 16,
    parameter int N_IN    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic [N_IN*WIDTH-1:0] op_data,
    input  logic                  op_ready,
    output logic                  start,
    input  logic                  result_en,
    input  logic [WIDTH-1:0]      result_data,
    input  logic                  done_next,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  err_no_result,
    output logic                  err_timeout,
    output logic [7:0]            frame_cnt
);

    localparam logic [1:0] S_LOAD   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_EMIT   = 2'd3;

    localparam int IDX_W = (N_IN > 2) ? $clog2(N_IN) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [1:0]            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [N_IN*WIDTH-1:0] op_q, op_d;
    logic [WIDTH-1:0]      res_q, res_d;
    logic                  have_res_q, have_res_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  err_nr_q, err_nr_d;
    logic                  err_to_q, err_to_d;
    logic [7:0]            frame_cnt_q, frame_cnt_d;

    logic accept;
    logic have_res_eff;

    assign in_ready      = (state_q == S_LOAD);
    assign accept        = in_valid && in_ready;
    assign start         = (state_q == S_LAUNCH) && op_ready;
    assign out_valid     = (state_q == S_EMIT);
    assign out_data      = res_q;
    assign op_data       = op_q;
    assign err_no_result = err_nr_q;
    assign err_timeout   = err_to_q;
    assign frame_cnt     = frame_cnt_q;

    // A capture in the same cycle as done_next still counts as a valid result.
    assign have_res_eff  = have_res_q || result_en;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        op_d        = op_q;
        res_d       = res_q;
        have_res_d  = have_res_q;
        wait_cnt_d  = wait_cnt_q;
        err_nr_d    = err_nr_q;
        err_to_d    = err_to_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    op_d[idx_q*WIDTH +: WIDTH] = in_data;
                    if (idx_q == IDX_W'(N_IN - 1)) begin
                        idx_d   = '0;
                        state_d = S_LAUNCH;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_LAUNCH: begin
                if (op_ready) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end
            end
            S_WAIT: begin
                if (result_en) begin
                    res_d      = result_data;
                    have_res_d = 1'b1;
                end
                if (done_next) begin
                    if (!have_res_eff) begin
                        err_nr_d = 1'b1;
                    end
                    wait_cnt_d = '0;
                    state_d    = S_EMIT;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Abort: the frame is dropped without output or count.
                    err_to_d   = 1'b1;
                    have_res_d = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = S_LOAD;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (out_ready) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    have_res_d  = 1'b0;
                    state_d     = S_LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_LOAD;
            idx_q       <= '0;
            op_q        <= '0;
            res_q       <= '0;
            have_res_q  <= 1'b0;
            wait_cnt_q  <= '0;
            err_nr_q    <= 1'b0;
            err_to_q    <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            res_q       <= res_d;
            have_res_q  <= have_res_d;
            wait_cnt_q  <= wait_cnt_d;
            err_nr_q    <= err_nr_d;
            err_to_q    <= err_to_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule
